// File: rtl/sar_release_sequencer_if.sv
// Lane/channel handshake bundle for the SaR release sequencer.
//   lane_stored  : lane i holds its next tuple           (lanes -> sequencer)
//   lane_last    : lane i has processed its last tuple   (lanes -> sequencer)
//   out_ready    : output channel i can accept           (channels -> sequencer)
//   out_valid    : tuple of lane i presented on channel i (sequencer -> channels)
//   lane_release : one-cycle retire pulse per lane       (sequencer -> lanes)
interface sar_release_sequencer_if #(
    parameter int unsigned NUM_LANES = 8
) ();
    logic [NUM_LANES-1:0] lane_stored;
    logic [NUM_LANES-1:0] lane_last;
    logic [NUM_LANES-1:0] out_ready;
    logic [NUM_LANES-1:0] out_valid;
    logic [NUM_LANES-1:0] lane_release;

    // Sequencer side
    modport master (
        input  lane_stored,
        input  lane_last,
        input  out_ready,
        output out_valid,
        output lane_release
    );

    // Lane / channel side
    modport slave (
        output lane_stored,
        output lane_last,
        output out_ready,
        input  out_valid,
        input  lane_release
    );
endinterface

// File: rtl/sar_release_sequencer.sv
// Lockstep release controller for the SaR lanes of the hash join output stage.
// Waits for every lane to hold a tuple, presents the set on all channels with
// per-lane valid/ready, never re-presents an accepted lane, then retires the
// whole set in one cycle. Counts sets, stall cycles and detects end-of-stream.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   start       : single-cycle pulse that begins a run
//   bus         : lane/channel handshake bundle (master side)
//   seq_num     : index of the current tuple set
//   stall_cnt   : saturating cycles spent waiting since the last set presented
//   busy, done  : run in progress / run finished
//   err         : sticky, a lane dropped its tuple before being accepted
module sar_release_sequencer #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned SEQ_W     = 32,
    parameter int unsigned STALL_W   = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    sar_release_sequencer_if.master bus,
    output logic [SEQ_W-1:0]        seq_num,
    output logic [STALL_W-1:0]      stall_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ALL = 3'd1,
        PRESENT  = 3'd2,
        RELEASE  = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_LANES-1:0] sent_mask;
    logic [NUM_LANES-1:0] sent_mask_d;
    logic [NUM_LANES-1:0] out_valid_d;
    logic [NUM_LANES-1:0] lane_release_d;
    logic [SEQ_W-1:0]     seq_num_d;
    logic [STALL_W-1:0]   stall_cnt_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 err_d;

    logic [NUM_LANES-1:0] hs_c;
    logic                 all_stored_c;
    logic                 end_of_stream_c;
    logic                 set_accepted_c;

    assign hs_c            = bus.out_valid & bus.out_ready;
    assign all_stored_c    = &bus.lane_stored;
    assign end_of_stream_c = (&bus.lane_last) && !(|bus.lane_stored);
    assign set_accepted_c  = &(sent_mask | hs_c);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = WAIT_ALL;
            WAIT_ALL: begin
                if (all_stored_c)         state_d = PRESENT;
                else if (end_of_stream_c) state_d = DONE;
            end
            PRESENT:  if (set_accepted_c) state_d = RELEASE;
            RELEASE:  state_d = WAIT_ALL;
            DONE:     if (start) state_d = WAIT_ALL;
            default:  state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and sent_mask
    always_comb begin
        out_valid_d    = '0;
        lane_release_d = '0;
        sent_mask_d    = sent_mask;
        seq_num_d      = seq_num;
        stall_cnt_d    = stall_cnt;
        err_d          = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    seq_num_d   = '0;
                    stall_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            WAIT_ALL: begin
                if (all_stored_c) begin
                    out_valid_d = '1;
                    sent_mask_d = '0;
                    stall_cnt_d = '0;
                end else if (!end_of_stream_c && (stall_cnt != '1)) begin
                    stall_cnt_d = stall_cnt + STALL_W'(1);
                end
            end
            PRESENT: begin
                sent_mask_d = sent_mask | hs_c;
                // Accepted lanes stay dark for the rest of the set
                out_valid_d = bus.out_valid & ~hs_c;
                if (set_accepted_c) lane_release_d = '1;
                // A lane not yet accepted must keep its tuple
                if (|(~bus.lane_stored & ~sent_mask)) err_d = 1'b1;
            end
            RELEASE: begin
                seq_num_d = seq_num + SEQ_W'(1);
            end
            DONE: begin
                if (start) begin
                    seq_num_d   = '0;
                    stall_cnt_d = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == WAIT_ALL) || (state_d == PRESENT) || (state_d == RELEASE);
        done_d = (state_d == DONE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.out_valid    <= '0;
            bus.lane_release <= '0;
            sent_mask        <= '0;
            seq_num          <= '0;
            stall_cnt        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            bus.out_valid    <= out_valid_d;
            bus.lane_release <= lane_release_d;
            sent_mask        <= sent_mask_d;
            seq_num          <= seq_num_d;
            stall_cnt        <= stall_cnt_d;
            busy             <= busy_d;
            done             <= done_d;
            err              <= err_d;
        end
    end

endmodule

// File: tb/tb_sar_release_sequencer.sv
// Directed-vector bench for sar_release_sequencer (8 lanes, 4-bit counters).
module tb_sar_release_sequencer;

    localparam int unsigned NL  = 8;
    localparam int unsigned SQW = 4;
    localparam int unsigned STW = 4;

    logic           clk;
    logic           resetn;
    logic           start;
    logic [SQW-1:0] seq_num;
    logic [STW-1:0] stall_cnt;
    logic           busy;
    logic           done;
    logic           err;

    sar_release_sequencer_if #(.NUM_LANES(NL)) bus ();

    sar_release_sequencer #(
        .NUM_LANES (NL),
        .SEQ_W     (SQW),
        .STALL_W   (STW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bus       (bus.master),
        .seq_num   (seq_num),
        .stall_cnt (stall_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           rstn;
        logic           st;
        logic [NL-1:0]  stored;
        logic [NL-1:0]  last;
        logic [NL-1:0]  ready;
        logic [NL-1:0]  e_valid;
        logic [NL-1:0]  e_rel;
        logic           e_busy;
        logic           e_done;
        logic           e_err;
        logic [SQW-1:0] e_seq;
        logic [STW-1:0] e_stall;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;
    int   idx;

    function automatic vec_t mk(string n, logic r, logic s,
                                logic [NL-1:0] sto, logic [NL-1:0] la, logic [NL-1:0] rdy,
                                logic [NL-1:0] ev, logic [NL-1:0] er,
                                logic eb, logic ed, logic ee,
                                logic [SQW-1:0] es, logic [STW-1:0] est);
        vec_t v;
        v.name = n; v.rstn = r; v.st = s;
        v.stored = sto; v.last = la; v.ready = rdy;
        v.e_valid = ev; v.e_rel = er;
        v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        v.e_seq = es; v.e_stall = est;
        return v;
    endfunction

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s[%0d] %s: got %h expected %h", nm, idx, fld, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle of inputs, then compare the registered outputs after the edge
    task automatic apply(vec_t v);
        resetn          = v.rstn;
        start           = v.st;
        bus.lane_stored = v.stored;
        bus.lane_last   = v.last;
        bus.out_ready   = v.ready;
        @(posedge clk);
        #1;
        chk(v.name, "out_valid",    32'(bus.out_valid),    32'(v.e_valid));
        chk(v.name, "lane_release", 32'(bus.lane_release), 32'(v.e_rel));
        chk(v.name, "busy",         32'(busy),             32'(v.e_busy));
        chk(v.name, "done",         32'(done),             32'(v.e_done));
        chk(v.name, "err",          32'(err),              32'(v.e_err));
        chk(v.name, "seq_num",      32'(seq_num),          32'(v.e_seq));
        chk(v.name, "stall_cnt",    32'(stall_cnt),        32'(v.e_stall));
        idx++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; idx = 0;
        resetn = 1'b0; start = 1'b0;
        bus.lane_stored = '0; bus.lane_last = '0; bus.out_ready = '0;

        //               name           rn st  stored last   ready  valid  rel    bz dn er seq   stall
        vecs.push_back(mk("reset0",      0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("reset1",      0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("start",       1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("present",     1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("release",     1, 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("retire",      1, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 4'd1, 4'd0));
        vecs.push_back(mk("split_pres",  1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 4'd1, 4'd0));
        vecs.push_back(mk("split_lo",    1, 1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00, 1, 0, 0, 4'd1, 4'd0));
        vecs.push_back(mk("split_hi",    1, 0, 8'hF0, 8'h00, 8'hF0, 8'h00, 8'hFF, 1, 0, 0, 4'd1, 4'd0));
        vecs.push_back(mk("split_ret",   1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd2, 4'd0));
        vecs.push_back(mk("stall1",      1, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd2, 4'd1));
        vecs.push_back(mk("stall2",      1, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd2, 4'd2));
        foreach (vecs[i]) apply(vecs[i]);

        // Long stall: counter saturates at 15 over 20 waiting cycles
        for (int i = 3; i <= 20; i++)
            apply(mk("stall_sat", 1, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd2,
                     (i > 15) ? 4'd15 : STW'(i)));

        vecs.delete();
        vecs.push_back(mk("stall_exit",  1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 4'd2, 4'd0));
        vecs.push_back(mk("err_hs0",     1, 0, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 4'd2, 4'd0));
        vecs.push_back(mk("err_drop",    1, 0, 8'hFD, 8'h00, 8'h00, 8'hFE, 8'h00, 1, 0, 1, 4'd2, 4'd0));
        vecs.push_back(mk("err_rel",     1, 0, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'hFF, 1, 0, 1, 4'd2, 4'd0));
        vecs.push_back(mk("err_ret",     1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'd3, 4'd0));
        vecs.push_back(mk("err_pres2",   1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 1, 4'd3, 4'd0));
        vecs.push_back(mk("err_rel2",    1, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0, 1, 4'd3, 4'd0));
        vecs.push_back(mk("err_ret2",    1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'd4, 4'd0));
        vecs.push_back(mk("last_notmt",  1, 0, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'd4, 4'd1));
        vecs.push_back(mk("done",        1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 1, 1, 4'd4, 4'd1));
        vecs.push_back(mk("done_hold",   1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 4'd4, 4'd1));
        vecs.push_back(mk("restart",     1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'd0, 4'd0));
        vecs.push_back(mk("prio",        1, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1, 0, 1, 4'd0, 4'd0));
        vecs.push_back(mk("prio_rel",    1, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0, 1, 4'd0, 4'd0));
        vecs.push_back(mk("prio_ret",    1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'd1, 4'd0));
        foreach (vecs[i]) apply(vecs[i]);

        // Back-to-back sets at peak rate; seq_num wraps from 15 to 0
        for (int k = 1; k <= 15; k++) begin
            apply(mk("wrap_pres", 1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 1, SQW'(k),     4'd0));
            apply(mk("wrap_rel",  1, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0, 1, SQW'(k),     4'd0));
            apply(mk("wrap_ret",  1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, SQW'(k + 1), 4'd0));
        end

        // Reset mid-PRESENT with half the lanes still pending
        vecs.delete();
        vecs.push_back(mk("rp_pres",     1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 1, 4'd0, 4'd0));
        vecs.push_back(mk("rp_half",     1, 0, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h00, 1, 0, 1, 4'd0, 4'd0));
        vecs.push_back(mk("rp_reset",    0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("rp_hold",     0, 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("rp_idle",     1, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("rp_start",    1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 4'd0, 4'd0));
        vecs.push_back(mk("rp_present",  1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 4'd0, 4'd0));
        foreach (vecs[i]) apply(vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
